// File: rtl/fir_serial_ctrl.sv
// fir_serial_ctrl: sequencer for a single-multiplier FIR (buffer zero-fill, sample write, TAPS MAC cycles, drain).
// Latency: write in c0, MAC in c1..cTAPS, valid in cTAPS+MAC_LAT; one sample every TAPS+MAC_LAT+2 cycles.
// Backpressure: ready only in IDLE; a sample offered while busy is dropped and sets the sticky ovf flag.
module fir_serial_ctrl #(
  parameter int TAPS    = 16,
  parameter int AW      = 4,
  parameter int DW      = 12,
  parameter int MAC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] xin,
  output logic          ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          valid,
  output logic          ovf
);

  localparam int DCW = $clog2(MAC_LAT + 1);

  // k is one bit wider than an address so it can count up to TAPS (the "all taps issued" marker)
  localparam logic [AW:0]     K_END = (AW+1)'(TAPS);
  localparam logic [AW:0]     K_ONE = (AW+1)'(1);
  localparam logic [DCW-1:0]  D_END = DCW'(MAC_LAT);
  localparam logic [DCW-1:0]  D_ONE = DCW'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_MAC,
    S_DRAIN
  } state_t;

  // state_q is the state of the current cycle; all output flops are loaded on the
  // edge that enters a cycle, so they always describe the cycle they are visible in.
  // k_q holds the next INIT address / next tap index to issue.
  state_t          state_q,     state_d;
  logic [AW:0]     k_q,         k_d;
  logic [DCW-1:0]  dcnt_q,      dcnt_d;
  logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [DW-1:0]   xreg_q,      xreg_d;
  logic            wr_en_q,     wr_en_d;
  logic [AW-1:0]   wr_addr_q,   wr_addr_d;
  logic [DW-1:0]   wr_data_q,   wr_data_d;
  logic [AW-1:0]   rd_addr_q,   rd_addr_d;
  logic [AW-1:0]   coef_addr_q, coef_addr_d;
  logic            mac_en_q,    mac_en_d;
  logic            mac_clr_q,   mac_clr_d;
  logic            valid_q,     valid_d;
  logic            ovf_q,       ovf_d;

  // Next-state and next-output decode; addresses and data hold unless rewritten
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    dcnt_d      = dcnt_q;
    wr_ptr_d    = wr_ptr_q;
    xreg_d      = xreg_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    coef_addr_d = coef_addr_q;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    valid_d     = 1'b0;
    // a strobe while busy is lost; remember it until reset
    ovf_d       = ovf_q | (en & (state_q != S_IDLE));

    case (state_q)
      S_INIT: begin
        if (k_q == K_END) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = k_q[AW-1:0];
          wr_data_d = '0;
          k_d       = k_q + K_ONE;
        end
      end
      S_IDLE: begin
        if (en) begin
          xreg_d    = xin;
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_data_d = xreg_d;
        end
      end
      S_WRITE: begin
        // tap 0 reads the sample just written, so the accumulator is cleared here
        state_d     = S_MAC;
        mac_en_d    = 1'b1;
        mac_clr_d   = 1'b1;
        coef_addr_d = '0;
        rd_addr_d   = wr_ptr_q;
        k_d         = K_ONE;
      end
      S_MAC: begin
        if (k_q == K_END) begin
          state_d = S_DRAIN;
          dcnt_d  = D_ONE;
          valid_d = (D_ONE == D_END);
        end else begin
          mac_en_d    = 1'b1;
          coef_addr_d = k_q[AW-1:0];
          rd_addr_d   = wr_ptr_q - k_q[AW-1:0];
          k_d         = k_q + K_ONE;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_END) begin
          state_d  = S_IDLE;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          dcnt_d  = dcnt_q + D_ONE;
          valid_d = ((dcnt_q + D_ONE) == D_END);
        end
      end
      default: begin
        state_d = S_INIT;
        k_d     = '0;
      end
    endcase
  end

  // State and output registers; reset restarts the zero-fill and cancels any result in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      k_q         <= '0;
      dcnt_q      <= '0;
      wr_ptr_q    <= '0;
      xreg_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      coef_addr_q <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      xreg_q      <= xreg_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      coef_addr_q <= coef_addr_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign coef_addr = coef_addr_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign valid     = valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// tb_fir_serial_ctrl: directed bench for the serial FIR sequencer with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Cycle naming follows the accept edge: c0 = write, c1..c16 = MAC, c18 = valid, c19 = ready.
module tb_fir_serial_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] xin;
  logic        ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  rd_addr;
  logic [3:0]  coef_addr;
  logic        mac_en;
  logic        mac_clr;
  logic        valid;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fir_serial_ctrl #(.TAPS(16), .AW(4), .DW(12), .MAC_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .xin       (xin),
    .ready     (ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .coef_addr (coef_addr),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .valid     (valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: reset for two edges, then run the 16 zero-fill cycles to the first ready cycle
  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (17) step();
  endtask

  task automatic test_reset();
    logic [29:0] exp_v;
    rst = 1'b1;
    en  = 1'b0;
    xin = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ready, wr_en, mac_en, mac_clr, valid, ovf, wr_addr, wr_data, rd_addr, coef_addr} !== 30'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i,
                 {ready, wr_en, mac_en, mac_clr, valid, ovf, wr_addr, wr_data, rd_addr, coef_addr});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 12'h000, 4'h0, 4'h0};
      checks++;
      if ({ready, wr_en, mac_en, mac_clr, valid, ovf, wr_addr, wr_data, rd_addr, coef_addr} !== exp_v) begin
        errors++;
        $display("FAIL init_write cycle %0d: got %h expected %h", i,
                 {ready, wr_en, mac_en, mac_clr, valid, ovf, wr_addr, wr_data, rd_addr, coef_addr}, exp_v);
      end
    end
    step();
    checks++;
    if ({ready, wr_en} !== 2'b10) begin
      errors++;
      $display("FAIL init_ready cycle 16: got ready,wr_en=%b expected 10", {ready, wr_en});
    end
  endtask

  task automatic test_single_sample();
    logic [3:0] exp_rd;
    logic       exp_clr;
    xin = 12'h7FF;
    en  = 1'b1;
    step();
    en  = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, mac_en, ready} !== {1'b1, 4'h0, 12'h7FF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_write c0: got en=%b addr=%h data=%h mac=%b rdy=%b expected 1 0 7ff 0 0",
               wr_en, wr_addr, wr_data, mac_en, ready);
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_rd  = 4'((16 - (c - 1)) % 16);
      exp_clr = (c == 1);
      checks++;
      if ({mac_en, mac_clr, coef_addr, rd_addr, wr_en, valid, ready} !==
          {1'b1, exp_clr, 4'(c - 1), exp_rd, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL single_mac c%0d: got mac=%b clr=%b coef=%h rd=%h wr=%b v=%b rdy=%b expected 1 %b %h %h 0 0 0",
                 c, mac_en, mac_clr, coef_addr, rd_addr, wr_en, valid, ready, exp_clr, 4'(c - 1), exp_rd);
      end
    end
    step();
    checks++;
    if ({mac_en, valid, ready, coef_addr, rd_addr} !== {1'b0, 1'b0, 1'b0, 4'hF, 4'h1}) begin
      errors++;
      $display("FAIL single_drain c17: got mac=%b v=%b rdy=%b coef=%h rd=%h expected 0 0 0 f 1",
               mac_en, valid, ready, coef_addr, rd_addr);
    end
    step();
    checks++;
    if ({valid, ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_valid c18: got valid,ready=%b expected 10", {valid, ready});
    end
    step();
    checks++;
    if ({valid, ready, ovf} !== 3'b010) begin
      errors++;
      $display("FAIL single_ready c19: got valid,ready,ovf=%b expected 010", {valid, ready, ovf});
    end
  endtask

  task automatic test_pointer_wrap();
    logic [11:0] x;
    do_reset();
    for (int s = 0; s <= 16; s++) begin
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_ready sample %0d: got %b expected 1", s, ready);
      end
      x   = 12'(s * 3 + 1);
      xin = x;
      en  = 1'b1;
      step();
      en  = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'(s % 16), x}) begin
        errors++;
        $display("FAIL wrap_write sample %0d: got en=%b addr=%h data=%h expected 1 %h %h",
                 s, wr_en, wr_addr, wr_data, 4'(s % 16), x);
      end
      step();
      checks++;
      if ({mac_en, mac_clr, rd_addr} !== {1'b1, 1'b1, 4'(s % 16)}) begin
        errors++;
        $display("FAIL wrap_rd0 sample %0d: got mac=%b clr=%b rd=%h expected 1 1 %h",
                 s, mac_en, mac_clr, rd_addr, 4'(s % 16));
      end
      step();
      checks++;
      if ({mac_en, mac_clr, rd_addr} !== {1'b1, 1'b0, 4'((s + 15) % 16)}) begin
        errors++;
        $display("FAIL wrap_rd1 sample %0d: got mac=%b clr=%b rd=%h expected 1 0 %h",
                 s, mac_en, mac_clr, rd_addr, 4'((s + 15) % 16));
      end
      for (int c = 3; c <= 19; c++) begin
        step();
        checks++;
        if (valid !== logic'(c == 18)) begin
          errors++;
          $display("FAIL wrap_valid sample %0d c%0d: got %b expected %b", s, c, valid, logic'(c == 18));
        end
      end
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_initial: got %b expected 0", ovf);
    end
    xin = 12'h123;
    en  = 1'b1;
    step();
    en  = 1'b0;
    repeat (5) step();
    xin = 12'hABC;
    en  = 1'b1;
    step();
    en  = 1'b0;
    checks++;
    if ({ovf, wr_en, mac_en, coef_addr} !== {1'b1, 1'b0, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL ovf_set c6: got ovf=%b wr=%b mac=%b coef=%h expected 1 0 1 5", ovf, wr_en, mac_en, coef_addr);
    end
    for (int c = 7; c <= 19; c++) begin
      step();
      checks++;
      if ({wr_en, valid, ovf} !== {1'b0, logic'(c == 18), 1'b1}) begin
        errors++;
        $display("FAIL ovf_timing c%0d: got wr,valid,ovf=%b expected 0%b1", c, {wr_en, valid, ovf}, logic'(c == 18));
      end
    end
    repeat (100) step();
    checks++;
    if ({ovf, ready, wr_en} !== 3'b110) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf,ready,wr=%b expected 110", {ovf, ready, wr_en});
    end
  endtask

  task automatic test_reset_mid_mac();
    xin = 12'h055;
    en  = 1'b1;
    step();
    en  = 1'b0;
    repeat (8) step();
    checks++;
    if ({mac_en, coef_addr} !== {1'b1, 4'd7}) begin
      errors++;
      $display("FAIL midrst_pre c8: got mac=%b coef=%h expected 1 7", mac_en, coef_addr);
    end
    rst = 1'b1;
    en  = 1'b1;
    step();
    checks++;
    if ({mac_en, wr_en, valid, ready, ovf, rd_addr, coef_addr, wr_addr, wr_data} !== 29'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h expected 0",
               {mac_en, wr_en, valid, ready, ovf, rd_addr, coef_addr, wr_addr, wr_data});
    end
    step();
    step();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_en_ovf: got %b expected 0", ovf);
    end
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({wr_en, wr_addr, wr_data, valid, mac_en, ready} !== {1'b1, 4'(i), 12'h000, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL midrst_init cycle %0d: got wr=%b addr=%h data=%h v=%b mac=%b rdy=%b expected 1 %h 000 0 0 0",
                 i, wr_en, wr_addr, wr_data, valid, mac_en, ready, 4'(i));
      end
    end
    step();
    checks++;
    if ({ready, valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_ready: got ready,valid=%b expected 10", {ready, valid});
    end
    xin = 12'h321;
    en  = 1'b1;
    step();
    en  = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'h0, 12'h321}) begin
      errors++;
      $display("FAIL midrst_write: got en=%b addr=%h data=%h expected 1 0 321", wr_en, wr_addr, wr_data);
    end
    for (int c = 1; c <= 19; c++) begin
      step();
      checks++;
      if (valid !== logic'(c == 18)) begin
        errors++;
        $display("FAIL midrst_valid c%0d: got %b expected %b", c, valid, logic'(c == 18));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    int n_wr    = 0;
    int n_mac   = 0;
    int n_clr   = 0;
    int last_v  = -1;
    int last_m  = -1;
    logic prev_mac = 1'b0;
    for (int i = 0; i < 230; i++) begin
      en  = (i < 200);
      xin = 12'(i);
      step();
      if (wr_en) n_wr++;
      if (mac_en) n_mac++;
      if (mac_clr) n_clr++;
      if (valid) begin
        n_valid++;
        if (last_v >= 0) begin
          checks++;
          if (i - last_v != 20) begin
            errors++;
            $display("FAIL stream_valid_gap at %0d: got %0d expected 20", i, i - last_v);
          end
        end
        last_v = i;
      end
      if (mac_en && !prev_mac) begin
        if (last_m >= 0) begin
          checks++;
          if (i - last_m != 20) begin
            errors++;
            $display("FAIL stream_mac_gap at %0d: got %0d expected 20", i, i - last_m);
          end
        end
        last_m = i;
      end
      prev_mac = mac_en;
    end
    en = 1'b0;
    checks++;
    if (n_valid != 10) begin
      errors++;
      $display("FAIL stream_valid_count: got %0d expected 10", n_valid);
    end
    checks++;
    if (n_wr != 10) begin
      errors++;
      $display("FAIL stream_write_count: got %0d expected 10", n_wr);
    end
    checks++;
    if (n_mac != 160 || n_clr != 10) begin
      errors++;
      $display("FAIL stream_mac_count: got mac=%0d clr=%0d expected 160 10", n_mac, n_clr);
    end
    checks++;
    if ({ovf, ready} !== 2'b11) begin
      errors++;
      $display("FAIL stream_ovf: got ovf,ready=%b expected 11", {ovf, ready});
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    xin = '0;
    test_reset();
    test_single_sample();
    test_pointer_wrap();
    test_overrun();
    test_reset_mid_mac();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
